patp_fetch_sequencer: RTL and testbench

Fetch/sequence control stage for the PATP core, sitting directly upstream of the instruction decoder. It owns the program counter and instruction register, fetches each instruction from program memory over a req/ack handshake, and presents the opcode with a one-cycle decode enable. It then holds in execute until the datapath signals completion, and applies jump targets supplied by the execution side.

---
 rtl/patp_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_patp_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/patp_fetch_sequencer.sv
// PATP fetch/sequence stage: owns pc and ir, fetches over a req/ack handshake,
// pulses the decoder, then waits in execute for the datapath to finish.
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | mem_req high at mem_addr=pc, waiting for mem_ack
// DECODE | ir valid, dec_enable pulse for one cycle
// EXEC   | waiting for exec_done; jump target applied on pc_load
module patp_fetch_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              dec_enable,
    input  logic              exec_done,
    input  logic              pc_load,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend on state only, so no input reaches an output combinationally.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        dec_enable = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                dec_enable = 1'b1;
                state_nxt  = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
        end else begin
            if (state == FETCH && mem_ack) begin
                ir <= mem_rdata;
                pc <= pc + ADDR_W'(1);
            end
            if (state == EXEC && exec_done) begin
                instr_count <= instr_count + 8'd1;
                if (pc_load) begin
                    pc <= operand;
                end
            end
        end
    end

    assign mem_addr = pc;
    assign opcode   = ir[DATA_W-1 -: 3];
    assign operand  = ir[ADDR_W-1:0];

endmodule

// File: tb/tb_patp_fetch_sequencer.sv
// Directed bench for patp_fetch_sequencer: a small memory/datapath responder
// plus hand-computed expectations for each scenario.
module tb_patp_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       dec_enable;
    logic       exec_done;
    logic       pc_load;
    logic       busy;
    logic [4:0] pc;
    logic [7:0] instr_count;

    patp_fetch_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .opcode      (opcode),
        .operand     (operand),
        .dec_enable  (dec_enable),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .busy        (busy),
        .pc          (pc),
        .instr_count (instr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [32];
    logic       auto_en;
    int         ack_lat;
    int         done_lat;
    logic       jump_en;

    logic       a_ack, a_done, a_load;
    logic [7:0] a_rdata;
    logic       m_ack, m_done, m_load;
    logic [7:0] m_rdata;

    assign mem_ack   = auto_en ? a_ack   : m_ack;
    assign mem_rdata = auto_en ? a_rdata : m_rdata;
    assign exec_done = auto_en ? a_done  : m_done;
    assign pc_load   = auto_en ? a_load  : m_load;

    int         cyc = 0;
    int         dec_q [$];
    int         req_len = 0, last_req_len = 0;
    int         exec_len = 0, last_exec_len = 0;
    logic [4:0] req_addr;
    logic [2:0] exec_op;
    logic       addr_moved, op_moved, in_exec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Observation and auto-responder, evaluated 1 time unit after each rising edge.
    initial begin
        a_ack = 0; a_done = 0; a_load = 0; a_rdata = '0;
        addr_moved = 0; op_moved = 0; req_addr = '0; exec_op = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (dec_enable) dec_q.push_back(cyc);
            if (mem_req) begin
                if (req_len > 0 && mem_addr != req_addr) addr_moved = 1;
                req_addr = mem_addr;
                req_len++;
            end else begin
                if (req_len > 0) last_req_len = req_len;
                req_len = 0;
            end
            in_exec = busy && !mem_req && !dec_enable;
            if (in_exec) begin
                if (exec_len > 0 && opcode != exec_op) op_moved = 1;
                exec_op = opcode;
                exec_len++;
            end else begin
                if (exec_len > 0) last_exec_len = exec_len;
                exec_len = 0;
            end
            a_ack   = mem_req && (req_len == ack_lat + 1);
            a_rdata = a_ack ? mem[mem_addr] : 8'h00;
            a_done  = in_exec && (exec_len == done_lat + 1);
            a_load  = a_done && jump_en;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        check_val(tag, busy, 0);
    endtask

    int c0, d0, cnt_before;
    logic found;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'h47;
        mem[3] = 8'h1F; mem[31] = 8'h83;
        auto_en = 1; ack_lat = 0; done_lat = 0; jump_en = 0;
        m_ack = 0; m_done = 0; m_load = 0; m_rdata = '0;
        rst_n = 0; run = 0;

        // Reset and idle
        repeat (3) step();
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1;
        repeat (10) step();
        check_val("idle_mem_req", mem_req, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_pc", pc, 0);
        check_val("idle_opcode", opcode, 0);
        check_val("idle_no_dec", dec_q.size(), 0);

        // Straight-line fetch, single-cycle ack and done; cycle where run is first seen counts as 1
        c0 = cyc; d0 = dec_q.size();
        run = 1;
        for (int n = 0; n < 20 && dec_q.size() < d0 + 2; n++) step();
        run = 0;
        check_val("line_dec_count", dec_q.size() - d0, 2);
        wait_idle(10, "line_idle_timeout");
        check_val("line_dec1_cycle", dec_q[d0] - c0 + 1, 3);
        check_val("line_dec2_cycle", dec_q[d0 + 1] - c0 + 1, 6);
        check_val("line_pc", pc, 2);
        check_val("line_opcode_last", opcode, 2);
        check_val("line_operand_last", operand, 5);
        check_val("line_count", instr_count, 2);

        // Slow memory and execute; run dropped during the pending fetch
        ack_lat = 4; done_lat = 3;
        addr_moved = 0; op_moved = 0; last_req_len = 0; last_exec_len = 0;
        d0 = dec_q.size();
        run = 1;
        step();
        run = 0;
        check_val("slow_req", mem_req, 1);
        check_val("slow_addr", mem_addr, 2);
        wait_idle(40, "slow_idle_timeout");
        check_val("slow_req_len", last_req_len, 5);
        check_val("slow_addr_stable", addr_moved, 0);
        check_val("slow_dec_pulses", dec_q.size() - d0, 1);
        check_val("slow_exec_len", last_exec_len, 4);
        check_val("slow_op_stable", op_moved, 0);
        check_val("slow_opcode", opcode, 2);
        check_val("slow_operand", operand, 7);
        check_val("slow_pc", pc, 3);
        check_val("slow_count", instr_count, 3);

        // Jump to 31, wrap on fetch, jump back to 3
        ack_lat = 0; done_lat = 0; jump_en = 1;
        run = 1;
        found = 0;
        cnt_before = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            step();
            if (dec_enable && opcode == 3'd4) begin
                found = 1;
                check_val("wrap_pc", pc, 0);
                check_val("wrap_operand", operand, 3);
                cnt_before = instr_count;
                run = 0;
            end
        end
        run = 0;
        check_val("wrap_found", found, 1);
        wait_idle(10, "jump_idle_timeout");
        check_val("jump_pc", pc, 3);
        check_val("jump_count", instr_count, cnt_before + 1);
        check_val("jump_count_abs", instr_count, 5);
        jump_en = 0;
        run = 1;
        step();
        run = 0;
        check_val("jump_next_req", mem_req, 1);
        check_val("jump_next_addr", mem_addr, 3);
        wait_idle(10, "jump_next_idle_timeout");
        check_val("jump_next_pc", pc, 4);

        // Stray strobes and stop, manually driven
        auto_en = 0;
        run = 1;
        step();
        check_val("stray_fetch_addr", mem_addr, 4);
        m_ack = 1; m_rdata = 8'h6A;
        step();
        check_val("stray_dec", dec_enable, 1);
        check_val("stray_dec_pc", pc, 5);
        m_ack = 1; m_rdata = 8'hFF; m_done = 1; m_load = 1;
        step();
        check_val("stray_exec_pc", pc, 5);
        check_val("stray_exec_opcode", opcode, 3);
        check_val("stray_exec_operand", operand, 10);
        check_val("stray_exec_count", instr_count, 6);
        check_val("stray_exec_req", mem_req, 0);
        m_done = 0; m_load = 1; run = 0;
        step();
        check_val("stray_hold_busy", busy, 1);
        check_val("stray_hold_pc", pc, 5);
        check_val("stray_hold_opcode", opcode, 3);
        check_val("stray_hold_count", instr_count, 6);
        m_done = 1; m_load = 0; m_ack = 0;
        step();
        check_val("stop_busy", busy, 0);
        check_val("stop_count", instr_count, 7);
        check_val("stop_pc", pc, 5);
        m_done = 0; m_rdata = '0;
        step();
        check_val("stop_stay_idle", busy, 0);

        // Async reset in the middle of a fetch
        auto_en = 1; ack_lat = 10;
        run = 1;
        step();
        step();
        check_val("arst_pre_req", mem_req, 1);
        #1;
        rst_n = 0;
        #1;
        check_val("arst_mem_req", mem_req, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_pc", pc, 0);
        check_val("arst_count", instr_count, 0);
        check_val("arst_opcode", opcode, 0);
        run = 0;
        step();
        rst_n = 1;
        repeat (3) step();
        check_val("arst_after_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
